// File: rtl/parking_gate_controller.sv
// Parking lot entry/exit barrier controller: two independent barrier
// sequencers sharing one saturating occupancy counter.

module parking_gate_fsm #(
  parameter int unsigned MOVE_TIME    = 16,
  parameter int unsigned HOLD_TIMEOUT = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic grant,
  input  logic permit,
  input  logic pass,
  output logic motor_up,
  output logic motor_dn,
  output logic gate_open,
  output logic deny,
  output logic pass_cnt_c
);

  localparam int unsigned TMR_MAX = (MOVE_TIME > HOLD_TIMEOUT) ? MOVE_TIME : HOLD_TIMEOUT;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_OPENING,
    S_OPEN,
    S_CLOSING
  } state_e;

  state_e           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             pass_prev_q, pass_prev_d;
  logic             motor_up_q, motor_up_d;
  logic             motor_dn_q, motor_dn_d;
  logic             gate_open_q, gate_open_d;
  logic             deny_q, deny_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      tmr_q       <= '0;
      pass_prev_q <= 1'b0;
      motor_up_q  <= 1'b0;
      motor_dn_q  <= 1'b0;
      gate_open_q <= 1'b0;
      deny_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      pass_prev_q <= pass_prev_d;
      motor_up_q  <= motor_up_d;
      motor_dn_q  <= motor_dn_d;
      gate_open_q <= gate_open_d;
      deny_q      <= deny_d;
    end
  end

  // One timer serves both motor travel and open-hold; it restarts on every state change.
  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q + TMR_W'(1);
    pass_prev_d = pass;
    deny_d      = 1'b0;
    pass_cnt_c  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        tmr_d = '0;
        if (grant) begin
          if (permit) state_d = S_OPENING;
          else        deny_d  = 1'b1;
        end
      end
      S_OPENING: begin
        if (tmr_q == TMR_W'(MOVE_TIME - 1)) begin
          state_d = S_OPEN;
          tmr_d   = '0;
        end
      end
      S_OPEN: begin
        if (pass && !pass_prev_q) begin
          pass_cnt_c = 1'b1;
          state_d    = S_CLOSING;
          tmr_d      = '0;
        end else if (tmr_q == TMR_W'(HOLD_TIMEOUT - 1)) begin
          state_d = S_CLOSING;
          tmr_d   = '0;
        end
      end
      S_CLOSING: begin
        // A car in the beam while lowering reverses the barrier.
        if (pass) begin
          state_d = S_OPENING;
          tmr_d   = '0;
        end else if (tmr_q == TMR_W'(MOVE_TIME - 1)) begin
          state_d = S_IDLE;
          tmr_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        tmr_d   = '0;
      end
    endcase
    motor_up_d  = (state_d == S_OPENING);
    motor_dn_d  = (state_d == S_CLOSING);
    gate_open_d = (state_d == S_OPEN);
  end

  assign motor_up  = motor_up_q;
  assign motor_dn  = motor_dn_q;
  assign gate_open = gate_open_q;
  assign deny      = deny_q;

endmodule

module parking_gate_controller #(
  parameter int unsigned CAPACITY     = 8,
  parameter int unsigned CNT_W        = 4,
  parameter int unsigned MOVE_TIME    = 16,
  parameter int unsigned HOLD_TIMEOUT = 200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             unlock_in,
  input  logic             unlock_out,
  input  logic             pass_in,
  input  logic             pass_out,
  output logic             motor_up_in,
  output logic             motor_dn_in,
  output logic             gate_open_in,
  output logic             deny_in,
  output logic             motor_up_out,
  output logic             motor_dn_out,
  output logic             gate_open_out,
  output logic             deny_out,
  output logic [CNT_W-1:0] occupancy,
  output logic             full,
  output logic             empty
);

  logic [CNT_W-1:0] occ_q, occ_d;
  logic             inc_c, dec_c;

  parking_gate_fsm #(.MOVE_TIME(MOVE_TIME), .HOLD_TIMEOUT(HOLD_TIMEOUT)) u_entry (
    .clk        (clk),
    .rst        (rst),
    .grant      (unlock_in),
    .permit     (!full),
    .pass       (pass_in),
    .motor_up   (motor_up_in),
    .motor_dn   (motor_dn_in),
    .gate_open  (gate_open_in),
    .deny       (deny_in),
    .pass_cnt_c (inc_c)
  );

  parking_gate_fsm #(.MOVE_TIME(MOVE_TIME), .HOLD_TIMEOUT(HOLD_TIMEOUT)) u_exit (
    .clk        (clk),
    .rst        (rst),
    .grant      (unlock_out),
    .permit     (!empty),
    .pass       (pass_out),
    .motor_up   (motor_up_out),
    .motor_dn   (motor_dn_out),
    .gate_open  (gate_open_out),
    .deny       (deny_out),
    .pass_cnt_c (dec_c)
  );

  always_ff @(posedge clk) begin
    if (rst) occ_q <= '0;
    else     occ_q <= occ_d;
  end

  // Simultaneous entry and exit cancel; saturate at both ends.
  always_comb begin
    occ_d = occ_q;
    if (inc_c && !dec_c && (occ_q != CNT_W'(CAPACITY))) occ_d = occ_q + CNT_W'(1);
    else if (dec_c && !inc_c && (occ_q != '0))          occ_d = occ_q - CNT_W'(1);
  end

  assign occupancy = occ_q;
  assign full      = (occ_q == CNT_W'(CAPACITY));
  assign empty     = (occ_q == '0);

endmodule

// File: doc/parking_gate_controller.md
Name: parking_gate_controller

Overview:
- Consumes the registered `unlock_in` / `unlock_out` grants produced by the parking keypad/motion front end.
- Drives the entry and exit barrier motors through an open/hold/close sequence.
- Counts cars actually passing each barrier and maintains lot occupancy.
- Refuses entry when the lot is full and exit when it is empty.

Parameters:
- CAPACITY, 8: maximum cars in lot.
- CNT_W, 4: occupancy counter width; must satisfy 2^CNT_W > CAPACITY.
- MOVE_TIME, 16: clock cycles the barrier motor runs to fully open or fully close.
- HOLD_TIMEOUT, 200: cycles the barrier stays open waiting for a pass before auto-closing.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- unlock_in  in  1  entry grant from keypad handling; level, sampled each cycle.
- unlock_out  in  1  exit grant from keypad handling; level, sampled each cycle.
- pass_in  in  1  beam sensor behind entry barrier; high while car in beam.
- pass_out  in  1  beam sensor behind exit barrier.
- motor_up_in  out  1  entry barrier raise drive.
- motor_dn_in  out  1  entry barrier lower drive.
- gate_open_in  out  1  entry barrier fully open.
- deny_in  out  1  one-cycle pulse: entry grant refused (full).
- motor_up_out  out  1  exit barrier raise drive.
- motor_dn_out  out  1  exit barrier lower drive.
- gate_open_out  out  1  exit barrier fully open.
- deny_out  out  1  one-cycle pulse: exit grant refused (empty).
- occupancy  out  CNT_W  cars currently in lot.
- full  out  1  occupancy == CAPACITY.
- empty  out  1  occupancy == 0.

Behaviour:
- Reset (synchronous, active-high):
  - Both gate FSMs go to IDLE; all motor, open and deny outputs are 0.
  - occupancy = 0, full = 0, empty = 1.
  - Timers and edge registers are cleared.
  - Reset mid-sequence drops the motors in the same cycle with no close sequence.
- Two identical gate FSMs (entry, exit), each with states IDLE, OPENING, OPEN, CLOSING, plus one shared occupancy counter.
- IDLE:
  - Grant high and permitted (entry: !full; exit: !empty) -> OPENING next cycle; motor_up is high from that cycle.
  - Grant high and not permitted -> stay IDLE; deny pulses high for 1 cycle per sampled cycle the grant is high.
  - Grants are ignored in every other state.
- OPENING:
  - motor_up = 1 for exactly MOVE_TIME cycles, then OPEN.
- OPEN:
  - gate_open = 1; the hold timer counts from 0.
  - Rising edge of the pass sensor (registered previous value) -> count the pass, then CLOSING next cycle.
  - Timer reaches HOLD_TIMEOUT - 1 with no pass -> CLOSING; no count change.
  - Maximum of one counted pass per opening.
- CLOSING:
  - motor_dn = 1 for MOVE_TIME cycles, then IDLE.
  - Safety reversal: pass sensor high in any CLOSING cycle -> OPENING with the move timer restarted at full MOVE_TIME; no count change.
- Motor interlock: motor_up and motor_dn are never both high.
- Occupancy counter:
  - Entry pass increments; exit pass decrements; both in the same cycle leave it unchanged.
  - The count is registered and visible the cycle after the pass edge.
  - Saturates at CAPACITY and 0; out-of-range updates are ignored.
  - full and empty are combinational from occupancy.
- Full/empty checks use occupancy at grant time. A car already admitted but not yet passed still counts on pass, but saturation keeps the count ≤ CAPACITY.
- The two gates operate independently and concurrently.

Test Plan:
(Parameters used: CAPACITY=2, MOVE_TIME=4, HOLD_TIMEOUT=10.)
- Entry, normal pass: unlock_in high 1 cycle at T.
  - motor_up_in high T+1..T+4, gate_open_in high from T+5.
  - pass_in rises at T+7: occupancy 0→1 at T+8; motor_dn_in high T+8..T+11; IDLE at T+12.
- Entry timeout: grant, no pass.
  - gate_open_in stays high exactly 10 cycles, then close sequence runs.
  - occupancy stays 0.
- Full denial: occupancy=2, unlock_in high 3 cycles.
  - deny_in high 3 cycles; no motor activity; occupancy stays 2.
- Empty denial, then simultaneous passes:
  - At occupancy 0, unlock_out high -> deny_out pulse.
  - Later, at occupancy 1 with both gates OPEN, pass_in and pass_out rise in the same cycle -> occupancy stays 1.
- Safety reversal: pass_out asserted in the 2nd CLOSING cycle.
  - Next cycle motor_up_out high for 4 cycles, then OPEN.
  - occupancy unchanged.
- Reset mid-OPENING: rst high 1 cycle.
  - All motors 0 the next cycle; occupancy 0, empty=1.
  - A fresh grant then runs the full sequence.
